// File: rtl/hhk_loop_sched.sv
// Two-requester round-robin loop scheduler: accepts (a, b), counts b cycles
// incrementing a modulo 2048, then presents the result until it is taken.
module hhk_loop_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [10:0] req0_a,
  input  logic [10:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [10:0] req1_a,
  input  logic [10:0] req1_b,
  output logic        req1_ready,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [10:0] rsp_res,
  output logic        rsp_ovf,
  output logic        busy,
  output logic [10:0] cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; ready never depends on the same-side valid of the other channel's
  // acceptance, and the response stays frozen while rsp_valid=1 and rsp_ready=0.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] res;
  logic        id;
  logic        ovf;
  logic        last_grant;
  logic        grant0;
  logic        grant1;
  logic        accept0;
  logic        accept1;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = (state == IDLE) && !rst && !flush && grant0;
  assign req1_ready = (state == IDLE) && !rst && !flush && grant1;
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_res   = res;
  assign rsp_ovf   = ovf;
  assign rsp_id    = id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept0 || accept1) state_next = RUN;
      RUN:     if (cnt == 11'd0) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Flush only resets the FSM; the datapath registers keep their values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res        <= 11'd0;
      cnt        <= 11'd0;
      id         <= 1'b0;
      ovf        <= 1'b0;
      last_grant <= 1'b1;
    end else if (!flush) begin
      if (accept0) begin
        res        <= req0_a;
        cnt        <= req0_b;
        id         <= 1'b0;
        ovf        <= 1'b0;
        last_grant <= 1'b0;
      end else if (accept1) begin
        res        <= req1_a;
        cnt        <= req1_b;
        id         <= 1'b1;
        ovf        <= 1'b0;
        last_grant <= 1'b1;
      end else if (state == RUN && cnt != 11'd0) begin
        cnt <= cnt - 11'd1;
        res <= res + 11'd1;
        if (res == 11'd2047) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hhk_loop_sched.sv
// Directed plus randomized bench for hhk_loop_sched against an arithmetic
// reference: result (a+b) mod 2048, wrap flag, b+1 latency, round-robin grants.
module tb_hhk_loop_sched;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [10:0] req0_a;
  logic [10:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [10:0] req1_a;
  logic [10:0] req1_b;
  logic        req1_ready;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [10:0] rsp_res;
  logic        rsp_ovf;
  logic        busy;
  logic [10:0] cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int last_m    = 1;
  logic [12:0] exp_q[$];

  hhk_loop_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .busy(busy), .cnt(cnt)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic int exp_grant(input bit v0, input bit v1);
    if (v0 && v1) return (last_m == 1) ? 0 : 1;
    return v0 ? 0 : 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_res"}, rsp_res, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_ovf"}, rsp_ovf, 0);
  endtask

  // driver: one complete operation, entered and left at a falling edge
  task automatic do_op(input bit v0, input bit v1,
                       input logic [10:0] a0, input logic [10:0] b0,
                       input logic [10:0] a1, input logic [10:0] b1,
                       input int hold, input bit keep);
    int g, sum, edges;
    logic [10:0] a, b;
    logic [12:0] e;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = (hold == 0);
    #1;
    g = exp_grant(v0, v1);
    chk("grant0", req0_ready, (g == 0));
    chk("grant1", req1_ready, (g == 1));
    a = (g == 0) ? a0 : a1;
    b = (g == 0) ? b0 : b1;
    sum = int'(a) + int'(b);
    exp_q.push_back({g[0], (sum > 2047), 11'(sum % 2048)});
    @(posedge clk);
    last_m = g;
    @(negedge clk);
    if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    chk("busy_after_accept", busy, 1);
    chk("cnt_after_accept", cnt, b);
    edges = 0;
    while (!rsp_valid && edges < 3000) begin
      @(negedge clk);
      edges++;
    end
    chk("latency", edges, int'(b) + 1);
    e = exp_q.pop_front();
    chk("rsp_res", rsp_res, e[10:0]);
    chk("rsp_ovf", rsp_ovf, e[11]);
    chk("rsp_id", rsp_id, e[12]);
    if (hold > 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_res", rsp_res, e[10:0]);
        chk("hold_ovf", rsp_ovf, e[11]);
        chk("hold_id", rsp_id, e[12]);
        chk("hold_no_ready", {req0_ready, req1_ready}, 0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    int n;
    logic [10:0] ra0, ra1, rb0, rb1;
    rst = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 11'd0; req0_b = 11'd0; req1_a = 11'd0; req1_b = 11'd0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // first tie after reset goes to requester 0: a=5, b=3 -> 8
    do_op(1, 1, 11'd5, 11'd3, 11'd7, 11'd7, 0, 0);
    do_op(0, 1, 11'd0, 11'd0, 11'd100, 11'd0, 0, 0);
    do_op(1, 0, 11'd2040, 11'd10, 11'd0, 11'd0, 0, 0);

    // continuous contention: grants must alternate
    for (int i = 0; i < 4; i++)
      do_op(1, 1, 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 8)),
            11'($urandom_range(0, 2047)), 11'($urandom_range(0, 8)), 0, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // backpressure for 20 cycles in DONE
    do_op(1, 0, 11'd2047, 11'd1, 11'd0, 11'd0, 20, 0);

    // flush during RUN of a b=50 operation
    req0_valid = 1'b1; req0_a = 11'd300; req0_b = 11'd50;
    @(posedge clk);
    last_m = 0;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_flush_cnt", cnt, 45);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_cnt_hold", cnt, 45);
    chk("flush_res_hold", rsp_res, 305);
    req1_valid = 1'b1;
    #1;
    chk("flush_gates_ready", req1_ready, 0);
    @(negedge clk);
    chk("flush_no_accept", busy, 0);
    flush = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_rsp", rsp_valid, 0);
    end

    // randomized operations
    for (int i = 0; i < 20; i++) begin
      n   = $urandom_range(1, 3);
      ra0 = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2030, 2047)) : 11'($urandom_range(0, 2047));
      ra1 = 11'($urandom_range(0, 2047));
      rb0 = 11'($urandom_range(0, 40));
      rb1 = 11'($urandom_range(0, 40));
      do_op(n[0], n[1], ra0, rb0, ra1, rb1, ($urandom_range(0, 4) == 0) ? 3 : 0, 0);
    end

    // asynchronous reset while RUN with cnt=7
    req0_valid = 1'b1; req0_a = 11'd10; req0_b = 11'd20;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (cnt != 11'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_cnt7", cnt, 7);
    #2;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    last_m = 1;
    do_op(1, 0, 11'd1, 11'd1, 11'd0, 11'd0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hhk_loop_sched.md
HHK_LOOP_SCHED -- requirements
Module: hhk_loop_sched

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a  in  11  requester 0 start value
- req0_b  in  11  requester 0 loop count
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as the requester 0 ports, for requester 1
- flush  in  1  synchronous abort
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_res  out  11  result (a+b mod 2048)
- rsp_ovf  out  1  result wrapped past 2047
- busy  out  1  state is not IDLE
- cnt  out  11  live loop counter

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE.
REQ-004 In IDLE the arbiter SHALL grant one valid requester:
- only one valid: grant it.
- both valid: grant the requester not granted last (round-robin).
REQ-005 reqN_ready SHALL be 1 only in IDLE, only for the granted N, and only while rst=0 and flush=0.
- reqN_ready is combinational from state and the valids.
- The other ready SHALL be 0.
REQ-006 An accept SHALL occur on an edge where reqN_valid=1 and reqN_ready=1. On that edge:
- res<=reqN_a, cnt<=reqN_b, id<=N, ovf<=0, last_grant<=N;
- state<=RUN.
REQ-007 In RUN with cnt!=0, each edge SHALL do cnt<=cnt-1 and res<=res+1, wrapping modulo 2048.
- If res==2047 before the increment, ovf SHALL be set and stay set until the next accept.
REQ-008 In RUN with cnt==0, the next edge SHALL move to DONE; res and cnt SHALL hold.
REQ-009 rsp_valid SHALL be 1 exactly in DONE, first asserting b+1 edges after the accepting edge.
REQ-010 rsp_res, rsp_ovf and rsp_id SHALL be stable while rsp_valid=1.
REQ-011 On an edge in DONE with rsp_ready=1, state SHALL go to IDLE.
- A new accept SHALL NOT occur on that same edge; it occurs in IDLE at the earliest on the following edge.
REQ-012 While rsp_valid=1 and rsp_ready=0, the block SHALL hold DONE indefinitely.
REQ-013 flush=1 SHALL force state<=IDLE from any state on the next edge.
- No response is produced for the aborted operation.
- res, cnt and last_grant SHALL hold.
- flush has priority over accept and over the rsp handshake.
REQ-014 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-015 cnt SHALL reflect the internal counter every cycle.
- rsp_res SHALL equal the internal res register.
REQ-016 A requester that drops valid before being granted SHALL lose nothing; no state changes.
REQ-017 Invariant: at DONE, rsp_res == (a+b) mod 2048 and rsp_ovf == (a+b > 2047).

Reset
REQ-018 While rst=1, the block SHALL force the following values asynchronously:
- state=IDLE, res=0, cnt=0, id=0, ovf=0;
- last_grant=1, so requester 0 wins the first tie;
- rsp_valid=0, busy=0, req0_ready=req1_ready=0.
REQ-019 rst asserted mid-RUN or mid-DONE SHALL discard the operation; after release the block is in IDLE with reset values.
REQ-020 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-021 Single op: req0 a=5, b=3, rsp_ready=1.
- Expect accept, then rsp_valid 4 edges later.
- Expect rsp_res=8, rsp_id=0, rsp_ovf=0, then IDLE.
REQ-022 Zero count: req1 a=100, b=0.
- Expect rsp_valid 1 edge after accept, rsp_res=100, rsp_id=1.
REQ-023 Wrap: req0 a=2040, b=10.
- Expect rsp_res=2, rsp_ovf=1.
REQ-024 Contention: both valid continuously, rsp_ready=1.
- Grants SHALL alternate 0,1,0,1.
- Each rsp_id matches its grant.
REQ-025 Backpressure and flush:
- Hold rsp_ready=0 for 20 cycles in DONE: rsp_valid and the result stay stable, and no ready is asserted.
- Then flush=1 during RUN of a b=50 op: IDLE next edge, no rsp_valid.
REQ-026 Reset mid-op: assert rst during RUN with cnt=7.
- Outputs go to reset values immediately (async).
- After release, req0 a=1, b=1 yields rsp_res=2.
